mdu32: RTL and testbench

MDU32 -- requirements
Module: mdu32

---
 rtl/mdu32.sv | 194 +++++++++++++++++++
 tb/tb_mdu32.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu32.sv
// mdu32: iterative 32-bit multiply/divide unit retiring one result bit per RUN cycle.
// Define MDU_DIV_EN to build the divider; without it divide ops complete at once as no-ops.
module mdu32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opB_q, opB_d;
    logic [31:0] accHi_q, accHi_d;
    logic [31:0] accLo_q, accLo_d;
    logic        negQ_q, negQ_d;
    logic        nop_q, nop_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic        accept;
    logic        aNeg, bNeg;
    logic [31:0] aMag, bMag;
    logic [32:0] mulSum;
    logic [63:0] prodMag, prodFix;

    assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
    assign aNeg    = op[0] && a[31];
    assign bNeg    = op[0] && b[31];
    assign aMag    = aNeg ? (~a + 32'd1) : a;
    assign bMag    = bNeg ? (~b + 32'd1) : b;
    // Shift-add step: accHi holds the running partial product, accLo the unconsumed multiplier bits.
    assign mulSum  = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : 33'd0);
    assign prodMag = {accHi_q, accLo_q};
    assign prodFix = negQ_q ? (~prodMag + 64'd1) : prodMag;

`ifdef MDU_DIV_EN
    logic        isDiv_q, isDiv_d;
    logic        negR_q, negR_d;
    logic [31:0] aRaw_q, aRaw_d;
    logic [32:0] divShift, divTrial;
    logic [31:0] quoFix, remFix;

    // Restoring step: accHi is the partial remainder, accLo shifts dividend bits out and quotient bits in.
    assign divShift = {accHi_q, accLo_q[31]};
    assign divTrial = divShift - {1'b0, opB_q};
    assign quoFix   = negQ_q ? (~accLo_q + 32'd1) : accLo_q;
    assign remFix   = negR_q ? (~accHi_q + 32'd1) : accHi_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opB_d   = opB_q;
        accHi_d = accHi_q;
        accLo_d = accLo_q;
        negQ_d  = negQ_q;
        nop_d   = nop_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
`ifdef MDU_DIV_EN
        isDiv_d = isDiv_q;
        negR_d  = negR_q;
        aRaw_d  = aRaw_q;
`endif
        case (state_q)
            RUN: begin
                if (nop_q) begin
                    state_d = DONE;
                    dz_d    = 1'b0;
                end else if (cnt_q == 6'd32) begin
                    state_d = DONE;
`ifdef MDU_DIV_EN
                    if (isDiv_q) begin
                        if (opB_q == 32'd0) begin
                            hi_d = aRaw_q;
                            lo_d = 32'hFFFF_FFFF;
                            dz_d = 1'b1;
                        end else begin
                            hi_d = remFix;
                            lo_d = quoFix;
                            dz_d = 1'b0;
                        end
                    end else
`endif
                    begin
                        hi_d = prodFix[63:32];
                        lo_d = prodFix[31:0];
                        dz_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
`ifdef MDU_DIV_EN
                    if (isDiv_q) begin
                        if (!divTrial[32]) begin
                            accHi_d = divTrial[31:0];
                            accLo_d = {accLo_q[30:0], 1'b1};
                        end else begin
                            accHi_d = divShift[31:0];
                            accLo_d = {accLo_q[30:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        accHi_d = mulSum[32:1];
                        accLo_d = {mulSum[0], accLo_q[31:1]};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            cnt_d   = 6'd0;
            nop_d   = 1'b0;
            accHi_d = 32'd0;
            negQ_d  = aNeg ^ bNeg;
            if (op[1]) begin
`ifdef MDU_DIV_EN
                isDiv_d = 1'b1;
                negR_d  = aNeg;
                aRaw_d  = a;
                accLo_d = aMag;
                opB_d   = bMag;
`else
                nop_d   = 1'b1;
                accLo_d = 32'd0;
                opB_d   = 32'd0;
`endif
            end else begin
`ifdef MDU_DIV_EN
                isDiv_d = 1'b0;
`endif
                accLo_d = bMag;
                opB_d   = aMag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            opB_q   <= 32'd0;
            accHi_q <= 32'd0;
            accLo_q <= 32'd0;
            negQ_q  <= 1'b0;
            nop_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dz_q    <= 1'b0;
`ifdef MDU_DIV_EN
            isDiv_q <= 1'b0;
            negR_q  <= 1'b0;
            aRaw_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opB_q   <= opB_d;
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            negQ_q  <= negQ_d;
            nop_q   <= nop_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
`ifdef MDU_DIV_EN
            isDiv_q <= isDiv_d;
            negR_q  <= negR_d;
            aRaw_q  <= aRaw_d;
`endif
        end
    end

    assign busy = (state_q == RUN) && !nop_q;
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;
endmodule

// File: tb/tb_mdu32.sv
// tb_mdu32: randomized self-checking bench for mdu32 against an arithmetic reference model.
// Follows the build's MDU_DIV_EN setting so both configurations are checked.
module tb_mdu32;
`ifdef MDU_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] expHi = 32'd0;
    logic [31:0] expLo = 32'd0;

    mdu32 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Returns {dz, hi, lo} computed straight from the arithmetic definitions.
    function automatic logic [64:0] refModel(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] pHi,
                                             input logic [31:0] pLo);
        longint      sx, sy;
        logic [63:0] r, q;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'd0) begin
            r = {32'd0, x} * {32'd0, y};
            return {1'b0, r};
        end
        if (o == 2'd1) begin
            r = sx * sy;
            return {1'b0, r};
        end
        if (!DivEn) return {1'b0, pHi, pLo};
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'd2) return {1'b0, x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input int ignoreAt, input bit backToBack);
        logic [64:0] expv;
        int          lat;
        int          busyCnt;
        bit          nopOp;
        nopOp = o[1] && !DivEn;
        expv  = refModel(o, x, y, expHi, expLo);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (nopOp) checkOutput("busyNop", 64'(busy), 64'd0);
        lat     = 0;
        busyCnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busyCnt++;
            start = (k == ignoreAt);
            if (start) begin
                op = 2'($urandom);
                a  = $urandom;
                b  = $urandom;
            end
        end
        start = 1'b0;
        expHi = expv[63:32];
        expLo = expv[31:0];
        checkOutput("latency", 64'(lat), nopOp ? 64'd1 : 64'd33);
        checkOutput("busyCycles", 64'(busyCnt), nopOp ? 64'd0 : 64'd32);
        checkOutput("hi", 64'(hi), 64'(expHi));
        checkOutput("lo", 64'(lo), 64'(expLo));
        checkOutput("dz", 64'(dz), 64'(expv[64]));
        if (!backToBack) begin
            @(posedge clk); #1;
            checkOutput("donePulse", 64'(done), 64'd0);
            checkOutput("holdHiLo", {hi, lo}, {expHi, expLo});
        end
    endtask

    initial begin
        int doneSeen;
        logic [1:0]  rOp;
        logic [31:0] rA, rB;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetDone", 64'(done), 64'd0);
        checkOutput("resetHiLo", {hi, lo}, 64'd0);
        checkOutput("resetDz", 64'(dz), 64'd0);

        applyStimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus(2'd1, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        applyStimulus(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        applyStimulus(2'd2, 32'd10, 32'd0, 0, 1'b0);
        applyStimulus(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus(2'd3, 32'd20, 32'd0, 0, 1'b0);
        applyStimulus(2'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);

        // Ignored mid-run start, then a divide launched in the done cycle.
        applyStimulus(2'd0, 32'd6, 32'd7, 5, 1'b1);
        applyStimulus(2'd2, 32'd100, 32'd7, 0, 1'b0);
        applyStimulus(2'd2, 32'd9, 32'd3, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rOp = 2'($urandom);
            rA  = $urandom;
            rB  = $urandom;
            if ($urandom_range(0, 4) == 0) rB = 32'd0;
            else if ($urandom_range(0, 2) == 0) rB = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) rA = -rA;
            applyStimulus(rOp, rA, rB, 0, (i != 23) && ($urandom_range(0, 1) == 1));
        end

        applyStimulus(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
        start = 1'b1;
        op    = 2'd0;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expHi = 32'd0;
        expLo = 32'd0;
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortHiLo", {hi, lo}, 64'd0);
        checkOutput("abortDz", 64'(dz), 64'd0);
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        checkOutput("abortNoDone", 64'(doneSeen), 64'd0);

        reset = 1'b1;
        start = 1'b1;
        op    = 2'd0;
        a     = 32'd5;
        b     = 32'd5;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        checkOutput("resetOverStart", 64'(busy), 64'd0);
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        checkOutput("resetStartNoDone", 64'(doneSeen), 64'd0);
        checkOutput("resetStartHiLo", {hi, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
